// File: rtl/hs_arb_pkg.sv
// Shared types and defaults for the hiscore/CPU work-RAM arbiter.
package hs_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PAUSE,
    GRANT,
    BUSY,
    RELEASE
  } state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_HS
  } owner_t;

  localparam int unsigned DEF_RD_LAT    = 1;
  localparam int unsigned DEF_PAUSE_TMO = 1023;

endpackage

// File: rtl/hs_arb_mux.sv
// Combinational owner select driving the shared work-RAM port.
module hs_arb_mux
  import hs_arb_pkg::*;
#(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 8
) (
  input  logic          i_reset,
  input  owner_t        i_owner,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic          i_cpu_we,
  input  logic [DW-1:0] i_cpu_wdata,
  input  logic [AW-1:0] i_hs_addr,
  input  logic          i_hs_we,
  input  logic [DW-1:0] i_hs_wdata,
  output logic [AW-1:0] o_ram_addr,
  output logic          o_ram_we,
  output logic [DW-1:0] o_ram_wdata
);

  always_comb begin
    o_ram_addr  = i_cpu_addr;
    o_ram_we    = i_cpu_we;
    o_ram_wdata = i_cpu_wdata;
    if (i_owner == OWN_HS) begin
      o_ram_addr  = i_hs_addr;
      o_ram_we    = i_hs_we;
      o_ram_wdata = i_hs_wdata;
    end
    // Never let a stale strobe corrupt RAM while the system is held in reset.
    if (i_reset) begin
      o_ram_we = 1'b0;
    end
  end

endmodule

// File: rtl/hs_ram_arbiter.sv
// Shares the game core's single-port work RAM between the CPU and the hiscore engine,
// pausing the CPU before handing the RAM over for a burst of hiscore accesses.
module hs_ram_arbiter
  import hs_arb_pkg::*;
#(
  parameter int unsigned AW        = 16,
  parameter int unsigned DW        = 8,
  parameter int unsigned RD_LAT    = DEF_RD_LAT,
  parameter int unsigned PAUSE_TMO = DEF_PAUSE_TMO
) (
  input  logic          i_clk_sys,
  input  logic          i_reset,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic          i_cpu_we,
  input  logic [DW-1:0] i_cpu_wdata,
  input  logic          i_hs_req,
  input  logic          i_hs_strobe,
  input  logic [AW-1:0] i_hs_addr,
  input  logic          i_hs_we,
  input  logic [DW-1:0] i_hs_wdata,
  output logic          o_hs_gnt,
  output logic          o_hs_ack,
  output logic [DW-1:0] o_hs_rdata,
  output logic          o_pause_req,
  input  logic          i_paused,
  output logic [AW-1:0] o_ram_addr,
  output logic          o_ram_we,
  output logic [DW-1:0] o_ram_wdata,
  input  logic [DW-1:0] i_ram_rdata,
  output logic          o_err_tmo,
  output logic          o_err_cpu_wr
);

  localparam int unsigned TMO_W = $clog2(PAUSE_TMO + 1);
  localparam int unsigned LAT_W = $clog2(RD_LAT + 1);

  state_t           r_state, w_state;
  owner_t           r_owner, w_owner;
  logic             r_pause_req, w_pause_req;
  logic             r_hs_gnt, w_hs_gnt;
  logic             r_hs_ack, w_hs_ack;
  logic [DW-1:0]    r_hs_rdata, w_hs_rdata;
  logic             r_err_tmo, w_err_tmo;
  logic             r_err_cpu_wr, w_err_cpu_wr;
  logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt;
  logic [LAT_W-1:0] r_lat_cnt, w_lat_cnt;
  logic [AW-1:0]    r_hs_addr, w_hs_addr;
  logic             r_tmo_block, w_tmo_block;
  logic             w_mux_hs_we;
  logic [AW-1:0]    w_mux_hs_addr;

  always_comb begin
    w_state       = r_state;
    w_owner       = r_owner;
    w_pause_req   = r_pause_req;
    w_hs_gnt      = r_hs_gnt;
    w_hs_ack      = 1'b0;
    w_hs_rdata    = r_hs_rdata;
    w_err_tmo     = r_err_tmo;
    w_err_cpu_wr  = r_err_cpu_wr | (i_cpu_we && (r_owner == OWN_HS));
    w_tmo_cnt     = r_tmo_cnt;
    w_lat_cnt     = r_lat_cnt;
    w_hs_addr     = r_hs_addr;
    // A timed-out request stays ignored until the engine drops hs_req once.
    w_tmo_block   = r_tmo_block & i_hs_req;
    w_mux_hs_we   = 1'b0;
    w_mux_hs_addr = i_hs_addr;

    case (r_state)
      IDLE: begin
        if (i_hs_req && !r_tmo_block) begin
          w_pause_req = 1'b1;
          w_tmo_cnt   = '0;
          w_state     = WAIT_PAUSE;
        end
      end
      WAIT_PAUSE: begin
        if (i_paused) begin
          w_hs_gnt = 1'b1;
          w_owner  = OWN_HS;
          w_state  = GRANT;
        end else if (!i_hs_req) begin
          w_pause_req = 1'b0;
          w_state     = IDLE;
        end else if (r_tmo_cnt == TMO_W'(PAUSE_TMO - 1)) begin
          w_err_tmo   = 1'b1;
          w_pause_req = 1'b0;
          w_tmo_block = 1'b1;
          w_state     = IDLE;
        end else begin
          w_tmo_cnt = r_tmo_cnt + TMO_W'(1);
        end
      end
      GRANT: begin
        if (i_hs_strobe) begin
          if (i_hs_we) begin
            w_mux_hs_we = 1'b1;
            w_hs_ack    = 1'b1;
            if (!i_hs_req) begin
              w_state = RELEASE;
            end
          end else begin
            w_hs_addr = i_hs_addr;
            w_lat_cnt = LAT_W'(1);
            w_state   = BUSY;
          end
        end else if (!i_hs_req) begin
          w_state = RELEASE;
        end
      end
      BUSY: begin
        // Keep presenting the read address until the RAM pipeline delivers.
        w_mux_hs_addr = r_hs_addr;
        if (r_lat_cnt == LAT_W'(RD_LAT)) begin
          w_hs_rdata = i_ram_rdata;
          w_hs_ack   = 1'b1;
          w_state    = GRANT;
        end else begin
          w_lat_cnt = r_lat_cnt + LAT_W'(1);
        end
      end
      RELEASE: begin
        w_hs_gnt    = 1'b0;
        w_pause_req = 1'b0;
        w_owner     = OWN_CPU;
        w_state     = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk_sys) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_owner      <= OWN_CPU;
      r_pause_req  <= 1'b0;
      r_hs_gnt     <= 1'b0;
      r_hs_ack     <= 1'b0;
      r_hs_rdata   <= '0;
      r_err_tmo    <= 1'b0;
      r_err_cpu_wr <= 1'b0;
      r_tmo_cnt    <= '0;
      r_lat_cnt    <= '0;
      r_hs_addr    <= '0;
      r_tmo_block  <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_owner      <= w_owner;
      r_pause_req  <= w_pause_req;
      r_hs_gnt     <= w_hs_gnt;
      r_hs_ack     <= w_hs_ack;
      r_hs_rdata   <= w_hs_rdata;
      r_err_tmo    <= w_err_tmo;
      r_err_cpu_wr <= w_err_cpu_wr;
      r_tmo_cnt    <= w_tmo_cnt;
      r_lat_cnt    <= w_lat_cnt;
      r_hs_addr    <= w_hs_addr;
      r_tmo_block  <= w_tmo_block;
    end
  end

  hs_arb_mux #(
    .AW(AW),
    .DW(DW)
  ) u_mux (
    .i_reset     (i_reset),
    .i_owner     (r_owner),
    .i_cpu_addr  (i_cpu_addr),
    .i_cpu_we    (i_cpu_we),
    .i_cpu_wdata (i_cpu_wdata),
    .i_hs_addr   (w_mux_hs_addr),
    .i_hs_we     (w_mux_hs_we),
    .i_hs_wdata  (i_hs_wdata),
    .o_ram_addr  (o_ram_addr),
    .o_ram_we    (o_ram_we),
    .o_ram_wdata (o_ram_wdata)
  );

  assign o_hs_gnt     = r_hs_gnt;
  assign o_hs_ack     = r_hs_ack;
  assign o_hs_rdata   = r_hs_rdata;
  assign o_pause_req  = r_pause_req;
  assign o_err_tmo    = r_err_tmo;
  assign o_err_cpu_wr = r_err_cpu_wr;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Self-checking bench for hs_ram_arbiter: models the work RAM and the pause system,
// and checks handshake timing and data against an expected-memory scoreboard.
module tb_hs_ram_arbiter;

  localparam int AW        = 16;
  localparam int DW        = 8;
  localparam int RD_LAT    = 2;
  localparam int PAUSE_TMO = 15;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_addr;
  logic          cpu_we;
  logic [DW-1:0] cpu_wdata;
  logic          hs_req, hs_strobe, hs_we;
  logic [AW-1:0] hs_addr;
  logic [DW-1:0] hs_wdata;
  logic          hs_gnt, hs_ack;
  logic [DW-1:0] hs_rdata;
  logic          pause_req, paused;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          err_tmo, err_cpu_wr;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] ram     [0:(1<<AW)-1];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];
  logic [AW-1:0] rd_pipe [RD_LAT];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  hs_ram_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .PAUSE_TMO(PAUSE_TMO)
  ) dut (
    .i_clk_sys   (clk_sys),
    .i_reset     (reset),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_we    (cpu_we),
    .i_cpu_wdata (cpu_wdata),
    .i_hs_req    (hs_req),
    .i_hs_strobe (hs_strobe),
    .i_hs_addr   (hs_addr),
    .i_hs_we     (hs_we),
    .i_hs_wdata  (hs_wdata),
    .o_hs_gnt    (hs_gnt),
    .o_hs_ack    (hs_ack),
    .o_hs_rdata  (hs_rdata),
    .o_pause_req (pause_req),
    .i_paused    (paused),
    .o_ram_addr  (ram_addr),
    .o_ram_we    (ram_we),
    .o_ram_wdata (ram_wdata),
    .i_ram_rdata (ram_rdata),
    .o_err_tmo   (err_tmo),
    .o_err_cpu_wr(err_cpu_wr)
  );

  always #5 clk_sys = ~clk_sys;

  // Work RAM: write on the edge, read data appears RD_LAT cycles after the address.
  always @(posedge clk_sys) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (ram_we) ram[ram_addr] <= ram_wdata;
    rd_pipe[0] <= ram_addr;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_rdata = ram[rd_pipe[RD_LAT-1]];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0;
    hs_req = 1'b0; hs_strobe = 1'b0; hs_we = 1'b0; hs_addr = '0; hs_wdata = '0;
    paused = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_addr = a; bd_data = d; bd_we = 1'b1;
    tick();
    bd_we = 1'b0;
    exp_mem[a] = d;
  endtask

  // Pause system model: answers pause_req after 'delay' cycles; grant must follow one cycle later.
  task automatic acquire(input int delay);
    cpu_addr = AW'($urandom);
    hs_req = 1'b1;
    for (int k = 1; k <= delay; k++) begin
      tick();
      settle();
      n_cmp++;
      if ({pause_req, hs_gnt, ram_addr} !== {1'b1, 1'b0, cpu_addr}) begin
        n_err++;
        $display("[TB] FAIL handshake_wait cycle %0d: got req=%b gnt=%b addr=%h, want req=1 gnt=0 addr=%h",
                 k, pause_req, hs_gnt, ram_addr, cpu_addr);
      end
    end
    paused = 1'b1;
    tick();
    n_cmp++;
    if ({pause_req, hs_gnt} !== 2'b11) begin
      n_err++;
      $display("[TB] FAIL grant_after_paused: got req=%b gnt=%b, want 1 1", pause_req, hs_gnt);
    end
    hs_addr = AW'($urandom);
    settle();
    n_cmp++;
    if (ram_addr !== hs_addr) begin
      n_err++;
      $display("[TB] FAIL grant_addr_owner: got %h want %h", ram_addr, hs_addr);
    end
  endtask

  task automatic release_bus();
    hs_req = 1'b0;
    tick();
    tick();
    settle();
    n_cmp++;
    if ({hs_gnt, pause_req, ram_addr} !== {1'b0, 1'b0, cpu_addr}) begin
      n_err++;
      $display("[TB] FAIL release: got gnt=%b req=%b addr=%h, want 0 0 %h", hs_gnt, pause_req, ram_addr, cpu_addr);
    end
    paused = 1'b0;
    tick();
  endtask

  // One hiscore access; writes must ack after 1 cycle, reads after RD_LAT+1.
  task automatic do_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int lat;
    bit got;
    logic [DW-1:0] want;
    want = we ? d : exp_mem[a];
    hs_strobe = 1'b1; hs_we = we; hs_addr = a; hs_wdata = d;
    tick();
    hs_strobe = 1'b0; hs_we = 1'b0; hs_addr = AW'($urandom); hs_wdata = DW'($urandom);
    lat = 1;
    got = 1'b0;
    while (!got && lat <= 8) begin
      if (hs_ack === 1'b1) got = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    n_cmp++;
    if (!got || lat != (we ? 1 : RD_LAT + 1)) begin
      n_err++;
      $display("[TB] FAIL ack_latency we=%0d addr=%h: got %0d (seen=%0d) want %0d", we, a, lat, got, we ? 1 : RD_LAT + 1);
    end
    if (!we) begin
      n_cmp++;
      if (hs_rdata !== want) begin
        n_err++;
        $display("[TB] FAIL read_data addr=%h: got %h want %h", a, hs_rdata, want);
      end
    end else begin
      exp_mem[a] = d;
    end
    tick();
    n_cmp++;
    if (hs_ack !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL ack_single_pulse: got %b want 0", hs_ack);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_we = 1'b1; cpu_addr = AW'($urandom);
    tick();
    settle();
    n_cmp++;
    if (ram_we !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_ram_we: got %b want 0", ram_we);
    end
    n_cmp++;
    if ({pause_req, hs_gnt, hs_ack, hs_rdata, err_tmo, err_cpu_wr} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got req=%b gnt=%b ack=%b rdata=%h tmo=%b cpuwr=%b, want all 0",
               pause_req, hs_gnt, hs_ack, hs_rdata, err_tmo, err_cpu_wr);
    end
    cpu_we = 1'b0;
    reset = 1'b0;
    tick();
    settle();
    n_cmp++;
    if (ram_addr !== cpu_addr) begin
      n_err++;
      $display("[TB] FAIL reset_owner_cpu: got %h want %h", ram_addr, cpu_addr);
    end
  endtask

  task automatic test_cpu_passthrough();
    for (int k = 0; k < 6; k++) begin
      cpu_addr = AW'($urandom); cpu_we = 1'($urandom); cpu_wdata = DW'($urandom);
      settle();
      n_cmp++;
      if ({ram_addr, ram_we, ram_wdata} !== {cpu_addr, cpu_we, cpu_wdata}) begin
        n_err++;
        $display("[TB] FAIL cpu_passthrough: got %h/%b/%h want %h/%b/%h",
                 ram_addr, ram_we, ram_wdata, cpu_addr, cpu_we, cpu_wdata);
      end
      if (cpu_we) exp_mem[cpu_addr] = cpu_wdata;
      tick();
    end
    cpu_we = 1'b0;
  endtask

  task automatic test_pause_handshake();
    acquire(5);
    release_bus();
    acquire($urandom_range(1, 12));
    release_bus();
  endtask

  task automatic test_write();
    acquire(3);
    hs_strobe = 1'b1; hs_we = 1'b1; hs_addr = 16'h0C40; hs_wdata = 8'h5A;
    settle();
    n_cmp++;
    if ({ram_we, ram_addr, ram_wdata, hs_ack} !== {1'b1, 16'h0C40, 8'h5A, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL write_bus: got we=%b addr=%h data=%h ack=%b, want 1 0c40 5a 0", ram_we, ram_addr, ram_wdata, hs_ack);
    end
    tick();
    hs_strobe = 1'b0; hs_we = 1'b0;
    n_cmp++;
    if (hs_ack !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL write_ack: got %b want 1", hs_ack);
    end
    exp_mem[16'h0C40] = 8'h5A;
    tick();
    n_cmp++;
    if (hs_ack !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL write_ack_end: got %b want 0", hs_ack);
    end
    do_access(1'b0, 16'h0C40, 8'h00);
    for (int k = 0; k < 3; k++) do_access(1'b1, AW'($urandom), DW'($urandom));
    release_bus();
  endtask

  task automatic test_read();
    preload(16'h0C41, 8'hA7);
    preload(16'h0C42, 8'h3C);
    acquire(2);
    hs_strobe = 1'b1; hs_we = 1'b0; hs_addr = 16'h0C41;
    tick();
    n_cmp++;
    if (hs_ack !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL read_early_ack1: got %b want 0", hs_ack);
    end
    hs_strobe = 1'b1; hs_we = 1'b1; hs_addr = 16'h0C42; hs_wdata = 8'hFF;
    settle();
    n_cmp++;
    if ({ram_we, ram_addr} !== {1'b0, 16'h0C41}) begin
      n_err++;
      $display("[TB] FAIL busy_hold: got we=%b addr=%h want 0 0c41", ram_we, ram_addr);
    end
    tick();
    hs_strobe = 1'b0; hs_we = 1'b0;
    n_cmp++;
    if (hs_ack !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL read_early_ack2: got %b want 0", hs_ack);
    end
    tick();
    n_cmp++;
    if ({hs_ack, hs_rdata} !== {1'b1, 8'hA7}) begin
      n_err++;
      $display("[TB] FAIL read_result: got ack=%b data=%h want 1 a7", hs_ack, hs_rdata);
    end
    tick();
    n_cmp++;
    if (hs_ack !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL read_ack_end: got %b want 0", hs_ack);
    end
    do_access(1'b0, 16'h0C42, 8'h00);
    release_bus();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] base;
    base = AW'($urandom) & ~AW'(7);
    acquire(4);
    for (int k = 0; k < 8; k++) do_access(1'b1, base + AW'(k), DW'($urandom));
    for (int k = 0; k < 20; k++) begin
      do_access(1'($urandom), base + AW'($urandom_range(0, 7)), DW'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    release_bus();
  endtask

  task automatic test_release();
    acquire(2);
    hs_strobe = 1'b1; hs_we = 1'b1; hs_addr = AW'($urandom); hs_wdata = DW'($urandom); hs_req = 1'b0;
    exp_mem[hs_addr] = hs_wdata;
    tick();
    hs_strobe = 1'b0; hs_we = 1'b0;
    n_cmp++;
    if (hs_ack !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL drop_write_ack: got %b want 1", hs_ack);
    end
    tick();
    settle();
    n_cmp++;
    if ({hs_gnt, pause_req, ram_addr} !== {1'b0, 1'b0, cpu_addr}) begin
      n_err++;
      $display("[TB] FAIL drop_release: got gnt=%b req=%b addr=%h want 0 0 %h", hs_gnt, pause_req, ram_addr, cpu_addr);
    end
    paused = 1'b0;
    tick();
    acquire(1);
    release_bus();
  endtask

  task automatic test_timeout();
    int high;
    bit stray;
    hs_req = 1'b1;
    tick();
    high = 0;
    for (int k = 0; k < PAUSE_TMO + 10; k++) begin
      if (pause_req !== 1'b1) break;
      high++;
      tick();
    end
    n_cmp++;
    if (high != PAUSE_TMO || err_tmo !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL timeout: got %0d cycles err=%b want %0d cycles err=1", high, err_tmo, PAUSE_TMO);
    end
    stray = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (pause_req !== 1'b0) stray = 1'b1;
    end
    n_cmp++;
    if (stray) begin
      n_err++;
      $display("[TB] FAIL timeout_block: got pause_req=1 while hs_req held, want 0");
    end
    hs_req = 1'b0;
    tick();
    hs_req = 1'b1;
    tick();
    n_cmp++;
    if (pause_req !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL timeout_rearm: got %b want 1", pause_req);
    end
    hs_req = 1'b0;
    tick();
    n_cmp++;
    if ({pause_req, err_tmo} !== 2'b01) begin
      n_err++;
      $display("[TB] FAIL timeout_sticky: got req=%b err=%b want 0 1", pause_req, err_tmo);
    end
  endtask

  task automatic test_cpu_conflict();
    acquire(2);
    cpu_we = 1'b1; cpu_addr = AW'($urandom); cpu_wdata = DW'($urandom);
    settle();
    n_cmp++;
    if ({ram_we, ram_addr} !== {1'b0, hs_addr}) begin
      n_err++;
      $display("[TB] FAIL conflict_blocked: got we=%b addr=%h want 0 %h", ram_we, ram_addr, hs_addr);
    end
    tick();
    cpu_we = 1'b0;
    n_cmp++;
    if (err_cpu_wr !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL conflict_flag: got %b want 1", err_cpu_wr);
    end
    release_bus();
    repeat (3) tick();
    n_cmp++;
    if (err_cpu_wr !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL conflict_sticky: got %b want 1", err_cpu_wr);
    end
  endtask

  task automatic test_reset_mid_read();
    bit late;
    acquire(2);
    hs_strobe = 1'b1; hs_we = 1'b0; hs_addr = AW'($urandom);
    tick();
    hs_strobe = 1'b0;
    reset = 1'b1;
    cpu_addr = AW'($urandom);
    tick();
    settle();
    n_cmp++;
    if ({pause_req, hs_gnt, hs_ack, ram_we, ram_addr} !== {4'b0000, cpu_addr}) begin
      n_err++;
      $display("[TB] FAIL reset_mid_read: got req=%b gnt=%b ack=%b we=%b addr=%h want 0 0 0 0 %h",
               pause_req, hs_gnt, hs_ack, ram_we, ram_addr, cpu_addr);
    end
    n_cmp++;
    if ({err_tmo, err_cpu_wr} !== 2'b00) begin
      n_err++;
      $display("[TB] FAIL reset_clears_err: got tmo=%b cpuwr=%b want 0 0", err_tmo, err_cpu_wr);
    end
    hs_req = 1'b0;
    paused = 1'b0;
    reset = 1'b0;
    late = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (hs_ack !== 1'b0 || pause_req !== 1'b0) late = 1'b1;
    end
    n_cmp++;
    if (late) begin
      n_err++;
      $display("[TB] FAIL reset_no_late_ack: got ack or pause_req after reset, want none");
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) tick();
    test_reset();
    test_cpu_passthrough();
    test_pause_handshake();
    test_write();
    test_read();
    test_back_to_back();
    test_release();
    test_timeout();
    test_cpu_conflict();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hs_ram_arbiter.md
Name: hs_ram_arbiter

Overview:
- Shares the game core's single-port work RAM between the CPU bus and the hiscore save/restore engine.
- The hiscore side never steals cycles from a running CPU. The arbiter requests a CPU pause, waits for the paused acknowledge, owns the RAM for a burst of hiscore accesses, then returns ownership.
- Sits between the hiscore engine and the game core RAM mux, alongside the pause system.

Parameters:
- AW, 16, RAM address width.
- DW, 8, RAM data width.
- RD_LAT, 1, RAM read latency in clk_sys cycles (1..3).
- PAUSE_TMO, 1023, max cycles to wait for paused before aborting; counter width is $clog2(PAUSE_TMO+1).

Ports:
- clk_sys  in  1  system clock (48 MHz).
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  AW  CPU RAM address.
- cpu_we  in  1  CPU write strobe.
- cpu_wdata  in  DW  CPU write data.
- hs_req  in  1  hiscore access intent (level); held for the whole burst.
- hs_strobe  in  1  single-cycle access strobe, valid only while hs_gnt=1.
- hs_addr  in  AW  hiscore address.
- hs_we  in  1  1=write, 0=read, sampled with hs_strobe.
- hs_wdata  in  DW  hiscore write data.
- hs_gnt  out  1  hiscore owns RAM.
- hs_ack  out  1  one-cycle completion pulse.
- hs_rdata  out  DW  read data, valid with hs_ack.
- pause_req  out  1  request CPU pause.
- paused  in  1  CPU is halted (from pause system).
- ram_addr  out  AW  muxed RAM address.
- ram_we  out  1  muxed RAM write enable.
- ram_wdata  out  DW  muxed RAM write data.
- ram_rdata  in  DW  RAM read data (RD_LAT after address).
- err_tmo  out  1  sticky: pause timeout occurred.
- err_cpu_wr  out  1  sticky: CPU write attempted while hiscore owned RAM.

Behaviour:
- Reset values: state IDLE, pause_req=0, hs_gnt=0, hs_ack=0, hs_rdata=0, err_*=0, owner=CPU.
- The ram_* outputs are combinational from the owner mux; ram_we is forced 0 in reset.
- FSM states: IDLE, WAIT_PAUSE, GRANT, BUSY, RELEASE.
- IDLE:
  - Owner=CPU: ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata.
  - hs_req=1 -> pause_req<=1, clear timeout counter, go to WAIT_PAUSE.
- WAIT_PAUSE:
  - Owner stays CPU; counter increments each cycle.
  - paused=1 -> GRANT, hs_gnt<=1, owner<=HS.
  - hs_req=0 -> IDLE, pause_req<=0.
  - Counter reaches PAUSE_TMO -> err_tmo<=1, pause_req<=0, go to IDLE.
  - After a timeout the arbiter ignores hs_req until it has been seen low for at least one cycle.
  - Priority within this state: paused > hs_req drop > timeout.
- GRANT:
  - Owner=HS; ram_we=0 unless strobed.
  - hs_strobe with hs_we=1: ram_we=1 for that cycle; hs_ack pulses the next cycle.
  - hs_strobe with hs_we=0: go to BUSY; ram_addr is held at the captured hs_addr.
  - hs_req=0 with no strobe -> RELEASE.
  - hs_strobe and hs_req falling in the same cycle: the access completes (ack issued), then RELEASE.
- BUSY (read):
  - Wait RD_LAT cycles.
  - Then hs_rdata<=ram_rdata, hs_ack=1, return to GRANT.
  - hs_strobe arriving during BUSY is ignored (one outstanding access).
- RELEASE:
  - One cycle: hs_gnt<=0, pause_req<=0, ram_we=0, owner<=CPU.
  - Then IDLE. hs_req re-assertion is honoured from IDLE.
- Any cpu_we=1 while owner=HS sets err_cpu_wr; the CPU write is never forwarded.
- paused dropping while in GRANT/BUSY: the access in flight still completes; no new grant is lost. The pause system is responsible for holding paused while pause_req=1.
- Synchronous reset mid-burst: returns to IDLE immediately, drops pause_req, no ack issued.
- Address/data widths pass through unchanged; no arithmetic beyond the counters.

Decomposition:
- Shared package hs_arb_pkg holds:
  - state enum (IDLE, WAIT_PAUSE, GRANT, BUSY, RELEASE),
  - owner enum (OWN_CPU, OWN_HS),
  - default RD_LAT and PAUSE_TMO constants.
- One natural sub-module: hs_arb_mux, the purely combinational owner-select for ram_addr/ram_we/ram_wdata. The FSM, timeout counter and read-latency counter stay in the top module.

Test Plan:
- Pause handshake: hs_req=1 while paused=0, then paused=1 after 5 cycles -> pause_req=1 from cycle 1, hs_gnt=1 exactly one cycle after paused rises, ram_addr follows hs side.
- Write: strobe hs_addr=0x0C40, hs_wdata=0x5A, hs_we=1 -> ram_we=1 that cycle with addr 0x0C40 and data 0x5A; hs_ack pulses next cycle.
- Read with RD_LAT=2: RAM model returns 0xA7 at 0x0C41; strobe a read -> hs_ack and hs_rdata=0xA7 exactly 3 cycles after strobe; a second strobe during BUSY is ignored.
- Timeout: PAUSE_TMO=15, paused held 0 -> err_tmo=1 after 15 cycles, pause_req=0, state IDLE; hs_req held high produces no new pause_req until it toggles low.
- CPU write conflict: cpu_we=1 during GRANT -> ram_we stays 0 (no hs strobe) and err_cpu_wr=1 persists until reset.
- Reset mid-read: assert reset in BUSY -> next cycle pause_req=0, hs_gnt=0, hs_ack=0, owner=CPU.
